// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared register-file write-back definitions: address width, special registers,
// the queued-write entry type and a zero-register helper.
package regfile_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int WB_DATA_W  = 32;

   localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'b00000;
   localparam logic [REG_ADDR_W-1:0] PC_REG   = 5'b01111;

   typedef struct packed {
      logic                  live;
      logic [REG_ADDR_W-1:0] addr;
      logic [WB_DATA_W-1:0]  data;
   } wb_entry_t;

   // Writes to $zero are never issued to the register file.
   function automatic logic is_zero_reg(input logic [REG_ADDR_W-1:0] addr);
      return (addr == ZERO_REG);
   endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Scalar/vector result inputs and register-file write port of the write-back arbiter.
interface regfile_wb_arbiter_if #(parameter int N = 32);

   logic          s_valid;
   logic [4:0]    s_addr;
   logic [N-1:0]  s_data;
   logic          v_valid;
   logic          v_ready;
   logic [4:0]    v_addr;
   logic [N-1:0]  v_data;
   logic [4:0]    A3;
   logic [N-1:0]  WD3;
   logic          WE3;
   logic [31:0]   pending;

   modport master (
      output s_valid, s_addr, s_data, v_valid, v_addr, v_data,
      input  v_ready, A3, WD3, WE3, pending
   );

   modport slave (
      input  s_valid, s_addr, s_data, v_valid, v_addr, v_data,
      output v_ready, A3, WD3, WE3, pending
   );

endinterface

// File: rtl/regfile_wb_arbiter_wb_queue.sv
// In-order vector result queue with squash-by-address and a pending-register mask.
module wb_queue
   import regfile_pkg::*;
#(
   parameter int N     = 32,
   parameter int DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  logic [REG_ADDR_W-1:0] push_addr,
   input  logic [N-1:0]          push_data,
   input  logic                  pop,
   input  logic                  squash_en,
   input  logic [REG_ADDR_W-1:0] squash_addr,
   output logic                  full,
   output logic                  empty,
   output logic                  head_live,
   output logic [REG_ADDR_W-1:0] head_addr,
   output logic [N-1:0]          head_data,
   output logic [31:0]           pending
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [DEPTH-1:0]      live_r;
   logic [REG_ADDR_W-1:0] addr_r [DEPTH];
   logic [N-1:0]          data_r [DEPTH];
   logic [PW-1:0]         wr_ptr_r;
   logic [PW-1:0]         rd_ptr_r;
   logic [CW-1:0]         count_r;
   logic [31:0]           pending_s;

   // Control state: live bits, pointers and occupancy; a push overrides a same-cycle squash.
   always_ff @(posedge clk) begin
      if (rst) begin
         live_r   <= '0;
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (squash_en && (addr_r[i] == squash_addr)) begin
               live_r[i] <= 1'b0;
            end
         end
         if (pop) begin
            live_r[rd_ptr_r] <= 1'b0;
            rd_ptr_r         <= rd_ptr_r + PW'(1);
         end
         if (push) begin
            live_r[wr_ptr_r] <= 1'b1;
            wr_ptr_r         <= wr_ptr_r + PW'(1);
         end
         case ({push, pop})
            2'b10:   count_r <= count_r + CW'(1);
            2'b01:   count_r <= count_r - CW'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Payload storage; only meaningful where the matching live bit is set.
   always_ff @(posedge clk) begin
      if (push) begin
         addr_r[wr_ptr_r] <= push_addr;
         data_r[wr_ptr_r] <= push_data;
      end
   end

   // One mask bit per register targeted by a live entry.
   always_comb begin
      pending_s = 32'h0000_0000;
      for (int i = 0; i < DEPTH; i++) begin
         pending_s = pending_s | (live_r[i] ? (32'h0000_0001 << addr_r[i]) : 32'h0000_0000);
      end
   end

   assign pending   = pending_s;
   assign full      = (count_r == CW'(DEPTH));
   assign empty     = (count_r == CW'(0));
   assign head_live = live_r[rd_ptr_r];
   assign head_addr = addr_r[rd_ptr_r];
   assign head_data = data_r[rd_ptr_r];

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Merges scalar and vector results onto the single register-file write port.
// Optional WB_BYPASS_EN: a lone vector result into an empty queue is written directly.
module regfile_wb_arbiter
   import regfile_pkg::*;
#(
   parameter int N     = 32,
   parameter int DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   regfile_wb_arbiter_if.slave  bus
);

   logic                  full_s;
   logic                  empty_s;
   logic                  head_live_s;
   logic [REG_ADDR_W-1:0] head_addr_s;
   logic [N-1:0]          head_data_s;
   logic [31:0]           pending_s;
   logic                  v_xfer_s;
   logic                  byp_s;
   logic                  push_s;
   logic                  pop_s;
   logic                  squash_s;
   logic                  we_nxt_s;
   logic [REG_ADDR_W-1:0] a_nxt_s;
   logic [N-1:0]          wd_nxt_s;
   logic                  we3_r;
   logic [REG_ADDR_W-1:0] a3_r;
   logic [N-1:0]          wd3_r;

   assign bus.v_ready = !full_s && !rst;
   assign v_xfer_s    = bus.v_valid && bus.v_ready;

`ifdef WB_BYPASS_EN
   assign byp_s = v_xfer_s && !bus.s_valid && empty_s;
`else
   assign byp_s = 1'b0;
`endif

   assign push_s   = v_xfer_s && !byp_s;
   assign pop_s    = !bus.s_valid && !empty_s;
   assign squash_s = bus.s_valid && !is_zero_reg(bus.s_addr);

   // Write selection: scalar, then queue head (dead heads drain silently), then bypass.
   always_comb begin
      we_nxt_s = 1'b0;
      a_nxt_s  = a3_r;
      wd_nxt_s = wd3_r;
      if (bus.s_valid) begin
         we_nxt_s = !is_zero_reg(bus.s_addr);
         a_nxt_s  = bus.s_addr;
         wd_nxt_s = bus.s_data;
      end else if (!empty_s) begin
         we_nxt_s = head_live_s && !is_zero_reg(head_addr_s);
         a_nxt_s  = head_addr_s;
         wd_nxt_s = head_data_s;
      end else if (byp_s) begin
         we_nxt_s = !is_zero_reg(bus.v_addr);
         a_nxt_s  = bus.v_addr;
         wd_nxt_s = bus.v_data;
      end else begin
         we_nxt_s = 1'b0;
      end
   end

   // Registered write port; address/data hold their last value between writes.
   always_ff @(posedge clk) begin
      if (rst) begin
         we3_r <= 1'b0;
         a3_r  <= '0;
         wd3_r <= '0;
      end else begin
         we3_r <= we_nxt_s;
         if (we_nxt_s) begin
            a3_r  <= a_nxt_s;
            wd3_r <= wd_nxt_s;
         end
      end
   end

   wb_queue #(.N(N), .DEPTH(DEPTH)) u_queue (
      .clk         (clk),
      .rst         (rst),
      .push        (push_s),
      .push_addr   (bus.v_addr),
      .push_data   (bus.v_data),
      .pop         (pop_s),
      .squash_en   (squash_s),
      .squash_addr (bus.s_addr),
      .full        (full_s),
      .empty       (empty_s),
      .head_live   (head_live_s),
      .head_addr   (head_addr_s),
      .head_data   (head_data_s),
      .pending     (pending_s)
   );

   assign bus.pending = pending_s;
   assign bus.A3      = a3_r;
   assign bus.WD3     = wd3_r;
   assign bus.WE3     = we3_r;

endmodule
